hub75_bcm_driver: RTL



---
 rtl/hub75_bcm_driver.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/hub75_bcm_driver.sv
// hub75_bcm_driver
//   HUB75(E) panel driver with binary-coded-modulation grey-scale. Each
//   handshake delivers one bit-plane of one row-pair. The driver shifts it
//   out on the six colour lines, then runs blank -> latch -> unblank. Because
//   the display timer runs independently of the FSM, the next plane is shifted
//   while the current one is still lit.
//
// Ports
//   clk, reset_n        system clock, synchronous active-low reset
//   s_valid/s_ready     plane-word handshake
//   {r,g,b}{0,1}_in     COLS plane bits per colour line, bit 0 shifted first
//   req_row/req_plane   row / bit-plane the driver expects next (MSB plane first)
//   {r,g,b}{0,1}_out    serial colour data
//   clk_out, latch_out  panel shift clock and latch strobe
//   blank               output enable, high = panel dark
//   addr_out            displayed row-pair address
//   frame_start         1-cycle pulse on the latch of row 0, top plane
//   underrun            sticky flag: display time ran out with no plane ready
module hub75_bcm_driver #(
  parameter int COLS       = 64,
  parameter int ROW_ADDR_W = 5,
  parameter int BCM_BITS   = 8,
  parameter int LSB_TICKS  = 82,
  parameter int CLK_DIV    = 2,
  localparam int PLANE_W   = (BCM_BITS > 1) ? $clog2(BCM_BITS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [COLS-1:0]       r0_in,
  input  logic [COLS-1:0]       g0_in,
  input  logic [COLS-1:0]       b0_in,
  input  logic [COLS-1:0]       r1_in,
  input  logic [COLS-1:0]       g1_in,
  input  logic [COLS-1:0]       b1_in,
  output logic [ROW_ADDR_W-1:0] req_row,
  output logic [PLANE_W-1:0]    req_plane,
  output logic                  r0_out,
  output logic                  g0_out,
  output logic                  b0_out,
  output logic                  r1_out,
  output logic                  g1_out,
  output logic                  b1_out,
  output logic                  clk_out,
  output logic                  latch_out,
  output logic                  blank,
  output logic [ROW_ADDR_W-1:0] addr_out,
  output logic                  frame_start,
  output logic                  underrun
);

  // Timer must hold the longest plane time without truncation.
  localparam longint unsigned MAX_TICKS = 64'(LSB_TICKS) << (BCM_BITS - 1);
  localparam int TIMER_W = (MAX_TICKS > 64'd1) ? $clog2(MAX_TICKS + 64'd1) : 1;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [PLANE_W-1:0] TOP_PLANE = PLANE_W'(BCM_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_WAIT,
    ST_BLANK,
    ST_LATCH,
    ST_UNBLANK
  } state_t;

  state_t state, state_next;

  // Shift chains, index 5..0 = r0,g0,b0,r1,g1,b1.
  logic [5:0][COLS-1:0]  sr;
  logic [DIV_W-1:0]      div_cnt;
  logic                  phase_hi;
  logic [COL_W-1:0]      col_cnt;
  logic [ROW_ADDR_W-1:0] cur_row;
  logic [PLANE_W-1:0]    cur_plane;
  logic [TIMER_W-1:0]    timer;
  logic                  displaying;
  // Keeps s_ready low during reset and the first cycle after it.
  logic                  armed;

  logic                  div_last;
  logic                  col_last;
  logic                  timer_run;
  logic                  xfer;
  logic [TIMER_W-1:0]    tick_load;

  assign div_last  = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign col_last  = (col_cnt == COL_W'(COLS - 1));
  assign timer_run = (timer != '0);
  assign xfer      = s_valid && s_ready;
  assign tick_load = TIMER_W'(LSB_TICKS) << cur_plane;

  // The panel is lit exactly while the display timer is running, so blank
  // also covers the BLANK/LATCH/UNBLANK steps (timer is 0 there).
  assign blank = ~timer_run;

  assign r0_out = sr[5][0];
  assign g0_out = sr[4][0];
  assign b0_out = sr[3][0];
  assign r1_out = sr[2][0];
  assign g1_out = sr[1][0];
  assign b1_out = sr[0][0];

  // Next-state and strobe decode.
  always_comb begin
    state_next  = state;
    s_ready     = 1'b0;
    clk_out     = 1'b0;
    latch_out   = 1'b0;
    frame_start = 1'b0;
    case (state)
      ST_IDLE: begin
        s_ready = armed;
        if (s_valid && armed) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        clk_out = phase_hi;
        if (div_last && phase_hi && col_last) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        // Shifted plane waits for the current one to finish its slot.
        if (!(timer_run && displaying)) state_next = ST_BLANK;
      end
      ST_BLANK: state_next = ST_LATCH;
      ST_LATCH: begin
        latch_out   = 1'b1;
        frame_start = (cur_row == '0) && (cur_plane == TOP_PLANE);
        state_next  = ST_UNBLANK;
      end
      ST_UNBLANK: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      armed      <= 1'b0;
      sr         <= '0;
      div_cnt    <= '0;
      phase_hi   <= 1'b0;
      col_cnt    <= '0;
      cur_row    <= '0;
      cur_plane  <= '0;
      req_row    <= '0;
      req_plane  <= TOP_PLANE;
      addr_out   <= '0;
      timer      <= '0;
      displaying <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state <= state_next;
      armed <= 1'b1;

      // Free-running countdown, overlapped with shifting.
      if (timer_run) timer <= timer - TIMER_W'(1);

      case (state)
        ST_IDLE: begin
          if (xfer) begin
            sr        <= {r0_in, g0_in, b0_in, r1_in, g1_in, b1_in};
            cur_row   <= req_row;
            cur_plane <= req_plane;
            div_cnt   <= '0;
            phase_hi  <= 1'b0;
            col_cnt   <= '0;
            // Planes are requested MSB first; row advances after plane 0.
            if (req_plane == '0) begin
              req_plane <= TOP_PLANE;
              req_row   <= req_row + ROW_ADDR_W'(1);
            end else begin
              req_plane <= req_plane - PLANE_W'(1);
            end
          end
        end
        ST_SHIFT: begin
          if (div_last) begin
            div_cnt  <= '0;
            phase_hi <= ~phase_hi;
            // Advance the chain at the end of the high half of a column.
            if (phase_hi) begin
              for (int i = 0; i < 6; i++) sr[i] <= sr[i] >> 1;
              col_cnt <= col_cnt + COL_W'(1);
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        ST_LATCH: addr_out <= cur_row;
        ST_UNBLANK: begin
          timer      <= tick_load;
          displaying <= 1'b1;
        end
        default: ;
      endcase

      // Display slot expired while the next plane was not yet latchable.
      if (!timer_run && displaying && (state == ST_IDLE || state == ST_SHIFT))
        underrun <= 1'b1;
    end
  end

endmodule
